// File: rtl/p2p_link_fifo.sv
// Elastic link buffer between a fixed-rate source and a valid/ready sink. Latency is 1 cycle, or 0 when empty with P2P_LINK_BYPASS_EN.
// The source is never stalled; sink backpressure fills the queue, after which arrivals are dropped and counted.
module p2p_link_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WIDTH-1:0]           in_msg,
  input  logic                       in_valid,
  output logic [WIDTH-1:0]           out_msg,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       drop_pulse,
  output logic [CNT_W-1:0]           drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             r_drop_pulse;
  logic [CNT_W-1:0] r_drop_cnt;

  logic w_empty;
  logic w_full;
  logic w_bypass;
  logic w_thru;
  logic w_pop;
  logic w_wr;
  logic w_drop;

  assign w_empty = (r_level == '0);
  assign w_full  = (r_level == LW'(DEPTH));

`ifdef P2P_LINK_BYPASS_EN
  // An arrival into an empty queue is shown directly; if taken now it never touches storage.
  assign w_bypass = w_empty & in_valid;
  assign w_thru   = w_bypass & out_ready;
`else
  assign w_bypass = 1'b0;
  assign w_thru   = 1'b0;
`endif

  assign w_pop  = !w_empty && out_ready;
  assign w_wr   = in_valid && !w_thru && (!w_full || w_pop);
  assign w_drop = in_valid && w_full && !w_pop;

  assign out_valid  = !w_empty || w_bypass;
  assign out_msg    = w_bypass ? in_msg : r_mem[r_rd_ptr];
  assign full       = w_full;
  assign empty      = w_empty;
  assign level      = r_level;
  assign drop_pulse = r_drop_pulse;
  assign drop_cnt   = r_drop_cnt;

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= in_msg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_level      <= '0;
      r_drop_pulse <= 1'b0;
      r_drop_cnt   <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_wr && !w_pop) begin
        r_level <= r_level + LW'(1);
      end else if (w_pop && !w_wr) begin
        r_level <= r_level - LW'(1);
      end
      r_drop_pulse <= w_drop;
      if (w_drop && (r_drop_cnt != {CNT_W{1'b1}})) begin
        r_drop_cnt <= r_drop_cnt + CNT_W'(1);
      end
    end
  end

endmodule
